// File: rtl/eth_mdio_pkg.sv
// Shared definitions for the Clause-22 MDIO responder: opcodes, frame
// field widths, last-bit indices for the shared bit counter, and the frame
// state enum.
package eth_mdio_pkg;

  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_WRITE = 2'b01;

  localparam int unsigned OP_BITS    = 2;
  localparam int unsigned PHYAD_BITS = 5;
  localparam int unsigned REGAD_BITS = 5;
  localparam int unsigned TA_BITS    = 2;
  localparam int unsigned DATA_BITS  = 16;

  // Value of the 5-bit field counter on the tick that samples a field's last bit
  localparam logic [4:0] OP_LAST    = 5'(OP_BITS - 1);
  localparam logic [4:0] PHYAD_LAST = 5'(PHYAD_BITS - 1);
  localparam logic [4:0] REGAD_LAST = 5'(REGAD_BITS - 1);
  localparam logic [4:0] TA_LAST    = 5'(TA_BITS - 1);
  localparam logic [4:0] DATA_LAST  = 5'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    PREAMBLE,
    START,
    OP,
    PHYAD,
    REGAD,
    TA,
    DATA
  } mdio_state_e;

endpackage

// File: rtl/eth_mdio_sync_edge.sv
// Synchronizes the asynchronous MDC/MDIO pins into clk_i and produces a
// one-cycle tick on every synchronized MDC rising edge.
//   clk_i, rst_ni  : system clock, async active-low reset
//   mdc_i, mdio_i  : raw pin values
//   tick_o         : 1-cycle pulse per MDC rising edge
//   mdio_sync_o    : synchronized MDIO, aligned with tick_o
module eth_mdio_sync_edge
  import eth_mdio_pkg::*;
#(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic tick_o,
  output logic mdio_sync_o
);

  logic [SyncStages-1:0] mdc_ff_q;
  logic [SyncStages-1:0] mdio_ff_q;
  logic                  mdc_prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mdc_ff_q   <= '0;
      mdio_ff_q  <= '0;
      mdc_prev_q <= 1'b0;
    end else begin
      mdc_ff_q   <= {mdc_ff_q[SyncStages-2:0], mdc_i};
      mdio_ff_q  <= {mdio_ff_q[SyncStages-2:0], mdio_i};
      mdc_prev_q <= mdc_ff_q[SyncStages-1];
    end
  end

  assign tick_o      = mdc_ff_q[SyncStages-1] & ~mdc_prev_q;
  assign mdio_sync_o = mdio_ff_q[SyncStages-1];

endmodule

// File: rtl/eth_mdio_responder.sv
// PHY-side Clause-22 MDIO responder. Decodes management frames sampled on
// MDC rising edges, presents reads/writes on a 16-bit register port and
// drives read data back onto MDIO.
//   clk_i, rst_ni       : system clock (>= 20x MDC), async active-low reset
//   mdc_i, mdio_i       : MDIO bus inputs (asynchronous)
//   mdio_o, mdio_oe     : MDIO drive value / drive enable
//   reg_addr_o          : REGAD of the most recent frame
//   reg_wdata_o         : write data, valid with reg_we_o
//   reg_we_o, reg_re_o  : one-cycle write / read strobes
//   reg_rdata_i         : read data, sampled one clk after reg_re_o
//   busy_o              : high from start bit until end of frame
module eth_mdio_responder
  import eth_mdio_pkg::*;
#(
  parameter logic [4:0]  PhyAddr      = 5'd1,
  parameter int unsigned PreambleBits = 32,
  parameter int unsigned SyncStages   = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic [4:0]  reg_addr_o,
  output logic [15:0] reg_wdata_o,
  output logic        reg_we_o,
  output logic        reg_re_o,
  input  logic [15:0] reg_rdata_i,
  output logic        busy_o
);

  localparam int unsigned     PcW    = (PreambleBits < 1) ? 1 : $clog2(PreambleBits + 1);
  localparam logic [PcW-1:0]  PreMax = PcW'(PreambleBits);

  logic tick, mdio_s;

  eth_mdio_sync_edge #(.SyncStages(SyncStages)) u_sync (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .mdc_i       (mdc_i),
    .mdio_i      (mdio_i),
    .tick_o      (tick),
    .mdio_sync_o (mdio_s)
  );

  mdio_state_e      state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [PcW-1:0]   pre_q, pre_d;
  logic [15:0]      sr_q, sr_d;
  logic             rd_q, rd_d;
  logic             match_q, match_d;
  logic             mdio_q, mdio_d;
  logic             oe_q, oe_d;
  logic [4:0]       addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             we_q, we_d;
  logic             re_q, re_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= PREAMBLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      sr_q    <= '0;
      rd_q    <= 1'b0;
      match_q <= 1'b0;
      mdio_q  <= 1'b0;
      oe_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      sr_q    <= sr_d;
      rd_q    <= rd_d;
      match_q <= match_d;
      mdio_q  <= mdio_d;
      oe_q    <= oe_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    sr_d    = sr_q;
    rd_d    = rd_q;
    match_d = match_q;
    mdio_d  = mdio_q;
    oe_d    = oe_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    busy_d  = busy_q;

    // Read data is loaded the clk after the read strobe; ticks are many
    // clks apart, so this never collides with a shift on a tick.
    if (re_q) sr_d = reg_rdata_i;

    if (tick) begin
      unique case (state_q)
        PREAMBLE: begin
          if (mdio_s) begin
            if (pre_q != PreMax) pre_d = pre_q + PcW'(1);
          end else if (pre_q >= PreMax) begin
            state_d = START;
          end else begin
            pre_d = '0;
          end
        end
        START: begin
          cnt_d = '0;
          if (mdio_s) begin
            state_d = OP;
            busy_d  = 1'b1;
          end else begin
            state_d = PREAMBLE;
            pre_d   = '0;
          end
        end
        OP: begin
          sr_d  = {sr_q[14:0], mdio_s};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == OP_LAST) begin
            cnt_d = '0;
            if ({sr_q[0], mdio_s} == OP_READ) begin
              rd_d    = 1'b1;
              state_d = PHYAD;
            end else if ({sr_q[0], mdio_s} == OP_WRITE) begin
              rd_d    = 1'b0;
              state_d = PHYAD;
            end else begin
              state_d = PREAMBLE;
              pre_d   = '0;
              busy_d  = 1'b0;
            end
          end
        end
        PHYAD: begin
          sr_d  = {sr_q[14:0], mdio_s};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == PHYAD_LAST) begin
            match_d = ({sr_q[3:0], mdio_s} == PhyAddr);
            cnt_d   = '0;
            state_d = REGAD;
          end
        end
        REGAD: begin
          sr_d  = {sr_q[14:0], mdio_s};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == REGAD_LAST) begin
            addr_d  = {sr_q[3:0], mdio_s};
            re_d    = rd_q & match_q;
            cnt_d   = '0;
            state_d = TA;
          end
        end
        TA: begin
          cnt_d = cnt_q + 5'd1;
          if (cnt_q != TA_LAST) begin
            if (rd_q && match_q) begin
              oe_d   = 1'b1;
              mdio_d = 1'b0;
            end
          end else begin
            if (rd_q && match_q) begin
              mdio_d = sr_q[15];
              sr_d   = {sr_q[14:0], 1'b0};
            end
            cnt_d   = '0;
            state_d = DATA;
          end
        end
        DATA: begin
          cnt_d = cnt_q + 5'd1;
          // Read frames shift out of bit 15; write frames shift in at bit 0.
          if (rd_q && match_q) begin
            mdio_d = sr_q[15];
            sr_d   = {sr_q[14:0], 1'b0};
          end else begin
            sr_d = {sr_q[14:0], mdio_s};
          end
          if (cnt_q == DATA_LAST) begin
            if (rd_q && match_q) begin
              oe_d   = 1'b0;
              mdio_d = 1'b0;
            end
            if (!rd_q && match_q) begin
              wdata_d = {sr_q[14:0], mdio_s};
              we_d    = 1'b1;
            end
            cnt_d   = '0;
            pre_d   = '0;
            busy_d  = 1'b0;
            state_d = PREAMBLE;
          end
        end
        default: state_d = PREAMBLE;
      endcase
    end
  end

  assign mdio_o      = mdio_q;
  assign mdio_oe     = oe_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_we_o    = we_q;
  assign reg_re_o    = re_q;
  assign busy_o      = busy_q;

endmodule
